// File: rtl/letter_scroll_ctrl.sv
// Scroll sequencer for a multiplexed letter display: buffers letter codes and
// time-multiplexes one seven-segment decoder across NUM_DIG digits, scrolling right-to-left.
module letter_scroll_ctrl #(
    parameter int unsigned NUM_DIG     = 4,
    parameter int unsigned MSG_MAX     = 16,
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned STEP_FRAMES = 25
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [4:0]         wr_data,
    output logic               wr_ready,
    input  logic               clr,
    input  logic               start,
    input  logic               stop,
    output logic               busy,
    output logic [4:0]         letra,
    output logic [NUM_DIG-1:0] dig_en,
    output logic               wrap_pulse
);

    localparam int unsigned LEN_W  = $clog2(MSG_MAX + 1);
    localparam int unsigned ADR_W  = (MSG_MAX > 1) ? $clog2(MSG_MAX) : 1;
    localparam int unsigned OFS_W  = $clog2(MSG_MAX + NUM_DIG);
    localparam int unsigned IDX_W  = OFS_W + 1;
    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    localparam int unsigned DIG_W  = $clog2(NUM_DIG);
    localparam int unsigned FRM_W  = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIG - 1);
    localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(STEP_FRAMES - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [LEN_W-1:0]   msg_len_q, msg_len_d;
    logic [SCAN_W-1:0]  scan_q, scan_d;
    logic [DIG_W-1:0]   dig_q, dig_d;
    logic [FRM_W-1:0]   frame_q, frame_d;
    logic [OFS_W-1:0]   offset_q, offset_d;
    logic [4:0]         letra_q, letra_d;
    logic [NUM_DIG-1:0] dig_en_q, dig_en_d;
    logic               wrap_q, wrap_d;
    logic [4:0]         msg_buf [MSG_MAX];

    logic [IDX_W-1:0]   stream_len, idx_sum, idx;
    logic [ADR_W-1:0]   buf_addr;
    logic               wr_fire;

    assign wr_ready   = (state_q == IDLE) && (msg_len_q < LEN_W'(MSG_MAX));
    assign wr_fire    = wr_en && wr_ready && !clr;
    assign busy       = (state_q == RUN);
    assign letra      = letra_q;
    assign dig_en     = dig_en_q;
    assign wrap_pulse = wrap_q;
    assign stream_len = IDX_W'(msg_len_q) + IDX_W'(NUM_DIG);

    always_comb begin
        state_d   = state_q;
        msg_len_d = msg_len_q;
        scan_d    = scan_q;
        dig_d     = dig_q;
        frame_d   = frame_q;
        offset_d  = offset_q;
        wrap_d    = 1'b0;

        if (state_q == IDLE && clr) begin
            msg_len_d = '0;
        end else if (wr_fire) begin
            msg_len_d = msg_len_q + LEN_W'(1);
        end

        if (state_q == IDLE) begin
            if (start && msg_len_q != '0) begin
                state_d = RUN;
            end
            scan_d   = '0;
            dig_d    = '0;
            frame_d  = '0;
            offset_d = '0;
        end else if (stop) begin
            state_d  = IDLE;
            scan_d   = '0;
            dig_d    = '0;
            frame_d  = '0;
            offset_d = '0;
        end else if (scan_q != SCAN_LAST) begin
            scan_d = scan_q + SCAN_W'(1);
        end else begin
            // Cascade: digit -> frame -> scroll offset, each advancing on the wrap of the one below.
            scan_d = '0;
            if (dig_q != DIG_LAST) begin
                dig_d = dig_q + DIG_W'(1);
            end else begin
                dig_d = '0;
                if (frame_q != FRM_LAST) begin
                    frame_d = frame_q + FRM_W'(1);
                end else begin
                    frame_d = '0;
                    if (IDX_W'(offset_q) + IDX_W'(1) == stream_len) begin
                        offset_d = '0;
                        wrap_d   = 1'b1;
                    end else begin
                        offset_d = offset_q + OFS_W'(1);
                    end
                end
            end
        end

        // Outputs are built from the next counter values so letra and dig_en stay coherent.
        idx_sum  = IDX_W'(offset_d) + IDX_W'(dig_d);
        idx      = (idx_sum >= stream_len) ? idx_sum - stream_len : idx_sum;
        buf_addr = ADR_W'(idx - IDX_W'(NUM_DIG));
        letra_d  = '0;
        dig_en_d = '0;
        if (state_d == RUN) begin
            dig_en_d = NUM_DIG'(1) << dig_d;
            if (idx >= IDX_W'(NUM_DIG)) begin
                letra_d = msg_buf[buf_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            msg_len_q <= '0;
            scan_q    <= '0;
            dig_q     <= '0;
            frame_q   <= '0;
            offset_q  <= '0;
            letra_q   <= '0;
            dig_en_q  <= '0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            msg_len_q <= msg_len_d;
            scan_q    <= scan_d;
            dig_q     <= dig_d;
            frame_q   <= frame_d;
            offset_q  <= offset_d;
            letra_q   <= letra_d;
            dig_en_q  <= dig_en_d;
            wrap_q    <= wrap_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            msg_buf[ADR_W'(msg_len_q)] <= wr_data;
        end
    end

endmodule
